// File: rtl/wb_xcpt_scheduler.sv
// Writeback exception scheduler: keeps the oldest pending exception reported by
// the ALU, MUL and cache writeback paths and raises it precisely at the ROB head.
module wb_xcpt_scheduler #(
    parameter int unsigned ROB_IDX_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_wb_valid,
    input  logic [ROB_IDX_W-1:0] alu_rob_id,
    input  logic [67:0]          alu_rob_xcpt_info,
    input  logic                 mul_wb_valid,
    input  logic [ROB_IDX_W-1:0] mul_rob_id,
    input  logic [67:0]          mul_rob_xcpt_info,
    input  logic                 cache_wb_valid,
    input  logic [ROB_IDX_W-1:0] cache_rob_id,
    input  logic [67:0]          cache_rob_xcpt_info,
    input  logic [ROB_IDX_W-1:0] rob_head,
    input  logic                 rob_head_done,
    input  logic                 ext_flush,
    input  logic                 xcpt_ack,
    output logic                 xcpt_pending,
    output logic                 xcpt_req,
    output logic [2:0]           xcpt_type,
    output logic [31:0]          xcpt_addr_val,
    output logic [31:0]          xcpt_pc,
    output logic [ROB_IDX_W-1:0] xcpt_rob_id,
    output logic                 rob_flush
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned XV_BIT = 67;

    typedef enum logic [1:0] {IDLE, HOLD, RAISE, FLUSH} state_t;

    state_t state;

    logic                 alu_cand_c, mul_cand_c, cache_cand_c;
    logic [ROB_IDX_W-1:0] alu_age_c, mul_age_c, cache_age_c, held_age_c;
    logic                 cand_valid_c;
    logic [ROB_IDX_W-1:0] cand_age_c;
    logic [ROB_IDX_W-1:0] cand_id_c;
    logic [66:0]          cand_info_c;

    // Ages are distances from the current head, so wrapped indices order correctly.
    assign alu_cand_c   = alu_wb_valid   && alu_rob_xcpt_info[XV_BIT];
    assign mul_cand_c   = mul_wb_valid   && mul_rob_xcpt_info[XV_BIT];
    assign cache_cand_c = cache_wb_valid && cache_rob_xcpt_info[XV_BIT];
    assign alu_age_c    = alu_rob_id   - rob_head;
    assign mul_age_c    = mul_rob_id   - rob_head;
    assign cache_age_c  = cache_rob_id - rob_head;
    assign held_age_c   = xcpt_rob_id  - rob_head;

    // Oldest candidate; strict compares give ALU > MUL > cache on equal age.
    always_comb begin
        cand_valid_c = 1'b0;
        cand_age_c   = '0;
        cand_id_c    = '0;
        cand_info_c  = '0;
        if (alu_cand_c) begin
            cand_valid_c = 1'b1;
            cand_age_c   = alu_age_c;
            cand_id_c    = alu_rob_id;
            cand_info_c  = alu_rob_xcpt_info[66:0];
        end
        if (mul_cand_c && (!cand_valid_c || (mul_age_c < cand_age_c))) begin
            cand_valid_c = 1'b1;
            cand_age_c   = mul_age_c;
            cand_id_c    = mul_rob_id;
            cand_info_c  = mul_rob_xcpt_info[66:0];
        end
        if (cache_cand_c && (!cand_valid_c || (cache_age_c < cand_age_c))) begin
            cand_valid_c = 1'b1;
            cand_age_c   = cache_age_c;
            cand_id_c    = cache_rob_id;
            cand_info_c  = cache_rob_xcpt_info[66:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            xcpt_pending  <= 1'b0;
            xcpt_req      <= 1'b0;
            xcpt_type     <= '0;
            xcpt_addr_val <= '0;
            xcpt_pc       <= '0;
            xcpt_rob_id   <= '0;
            rob_flush     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ext_flush && cand_valid_c) begin
                        state         <= HOLD;
                        xcpt_pending  <= 1'b1;
                        xcpt_type     <= cand_info_c[TYPE_W-1:0];
                        xcpt_addr_val <= cand_info_c[66:35];
                        xcpt_pc       <= cand_info_c[34:3];
                        xcpt_rob_id   <= cand_id_c;
                    end
                end
                HOLD: begin
                    if (ext_flush) begin
                        state         <= IDLE;
                        xcpt_pending  <= 1'b0;
                        xcpt_type     <= '0;
                        xcpt_addr_val <= '0;
                        xcpt_pc       <= '0;
                        xcpt_rob_id   <= '0;
                    end else if ((rob_head == xcpt_rob_id) && rob_head_done) begin
                        state    <= RAISE;
                        xcpt_req <= 1'b1;
                    end else if (cand_valid_c && (cand_age_c < held_age_c)) begin
                        xcpt_type     <= cand_info_c[TYPE_W-1:0];
                        xcpt_addr_val <= cand_info_c[66:35];
                        xcpt_pc       <= cand_info_c[34:3];
                        xcpt_rob_id   <= cand_id_c;
                    end
                end
                RAISE: begin
                    // Held fields stay frozen until core control acknowledges.
                    if (xcpt_ack) begin
                        state        <= FLUSH;
                        xcpt_req     <= 1'b0;
                        xcpt_pending <= 1'b0;
                        rob_flush    <= 1'b1;
                    end
                end
                FLUSH: begin
                    state         <= IDLE;
                    rob_flush     <= 1'b0;
                    xcpt_type     <= '0;
                    xcpt_addr_val <= ADDR_W'(0);
                    xcpt_pc       <= ADDR_W'(0);
                    xcpt_rob_id   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_xcpt_scheduler.sv
// Directed bench for wb_xcpt_scheduler: per-cycle vector table plus an
// asynchronous-reset-during-RAISE sequence.
module tb_wb_xcpt_scheduler;

    localparam int unsigned W = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          alu_wb_valid, mul_wb_valid, cache_wb_valid;
    logic [W-1:0]  alu_rob_id, mul_rob_id, cache_rob_id;
    logic [67:0]   alu_rob_xcpt_info, mul_rob_xcpt_info, cache_rob_xcpt_info;
    logic [W-1:0]  rob_head;
    logic          rob_head_done, ext_flush, xcpt_ack;
    logic          xcpt_pending, xcpt_req, rob_flush;
    logic [2:0]    xcpt_type;
    logic [31:0]   xcpt_addr_val, xcpt_pc;
    logic [W-1:0]  xcpt_rob_id;

    wb_xcpt_scheduler #(.ROB_IDX_W(W)) dut (
        .clock(clock), .reset(reset),
        .alu_wb_valid(alu_wb_valid), .alu_rob_id(alu_rob_id), .alu_rob_xcpt_info(alu_rob_xcpt_info),
        .mul_wb_valid(mul_wb_valid), .mul_rob_id(mul_rob_id), .mul_rob_xcpt_info(mul_rob_xcpt_info),
        .cache_wb_valid(cache_wb_valid), .cache_rob_id(cache_rob_id), .cache_rob_xcpt_info(cache_rob_xcpt_info),
        .rob_head(rob_head), .rob_head_done(rob_head_done), .ext_flush(ext_flush), .xcpt_ack(xcpt_ack),
        .xcpt_pending(xcpt_pending), .xcpt_req(xcpt_req), .xcpt_type(xcpt_type),
        .xcpt_addr_val(xcpt_addr_val), .xcpt_pc(xcpt_pc), .xcpt_rob_id(xcpt_rob_id),
        .rob_flush(rob_flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         av;   logic [W-1:0] aid; logic [67:0] ainfo;
        logic         mv;   logic [W-1:0] mid; logic [67:0] minfo;
        logic         cv;   logic [W-1:0] cid; logic [67:0] cinfo;
        logic [W-1:0] head; logic done; logic fl; logic ack;
        logic         e_pend; logic e_req; logic e_flush;
        logic [2:0]   e_type; logic [31:0] e_addr; logic [31:0] e_pc; logic [W-1:0] e_id;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [67:0] NONE = 68'h0;

    function automatic logic [67:0] mk(input logic v, input logic [31:0] addr,
                                       input logic [31:0] pc, input logic [2:0] ty);
        return {v, addr, pc, ty};
    endfunction

    task automatic add(input logic av, input logic [W-1:0] aid, input logic [67:0] ainfo,
                       input logic mv, input logic [W-1:0] mid, input logic [67:0] minfo,
                       input logic cv, input logic [W-1:0] cid, input logic [67:0] cinfo,
                       input logic [W-1:0] head, input logic done, input logic fl, input logic ack,
                       input logic ep, input logic er, input logic ef,
                       input logic [2:0] et, input logic [31:0] ea, input logic [31:0] epc,
                       input logic [W-1:0] eid);
        vec_t v;
        v.av = av; v.aid = aid; v.ainfo = ainfo;
        v.mv = mv; v.mid = mid; v.minfo = minfo;
        v.cv = cv; v.cid = cid; v.cinfo = cinfo;
        v.head = head; v.done = done; v.fl = fl; v.ack = ack;
        v.e_pend = ep; v.e_req = er; v.e_flush = ef;
        v.e_type = et; v.e_addr = ea; v.e_pc = epc; v.e_id = eid;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ep, input logic er, input logic ef,
                           input logic [2:0] et, input logic [31:0] ea, input logic [31:0] epc,
                           input logic [W-1:0] eid);
        chk({tag, ".pending"}, 32'(xcpt_pending), 32'(ep));
        chk({tag, ".req"},     32'(xcpt_req),     32'(er));
        chk({tag, ".flush"},   32'(rob_flush),    32'(ef));
        chk({tag, ".type"},    32'(xcpt_type),    32'(et));
        chk({tag, ".addr"},    xcpt_addr_val,     ea);
        chk({tag, ".pc"},      xcpt_pc,           epc);
        chk({tag, ".rob_id"},  32'(xcpt_rob_id),  32'(eid));
    endtask

    task automatic idle_inputs();
        alu_wb_valid = 1'b0; alu_rob_id = '0; alu_rob_xcpt_info = NONE;
        mul_wb_valid = 1'b0; mul_rob_id = '0; mul_rob_xcpt_info = NONE;
        cache_wb_valid = 1'b0; cache_rob_id = '0; cache_rob_xcpt_info = NONE;
        rob_head = '0; rob_head_done = 1'b0; ext_flush = 1'b0; xcpt_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Single ALU fault, ack on the first RAISE cycle, then one flush pulse.
        add(1,2,mk(1,0,32'h100,3), 0,0,NONE, 0,0,NONE, 2,0,0,0, 1,0,0, 3,0,32'h100,2);
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                2,1,0,0, 1,1,0, 3,0,32'h100,2);
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                2,0,0,1, 0,0,1, 3,0,32'h100,2);
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                2,0,0,0, 0,0,0, 0,0,0,0);
        // Simultaneous arrivals at head=5: MUL id5 is oldest.
        add(1,7,mk(1,32'h11,32'h111,1), 1,5,mk(1,32'h22,32'h200,2), 1,6,mk(1,32'h33,32'h333,6),
            5,0,0,0, 1,0,0, 2,32'h22,32'h200,5);
        // ext_flush in HOLD beats a same-cycle candidate; ext_flush in IDLE drops candidates.
        add(1,5,mk(1,32'h9,32'h999,7), 0,0,NONE, 0,0,NONE, 5,0,1,0, 0,0,0, 0,0,0,0);
        add(1,5,mk(1,32'h9,32'h999,7), 0,0,NONE, 0,0,NONE, 5,0,1,0, 0,0,0, 0,0,0,0);
        // Non-exception writebacks, exception info without valid, ack in IDLE.
        add(1,4,mk(0,1,2,3), 1,4,mk(0,1,2,3), 1,4,mk(0,1,2,3), 5,0,0,0, 0,0,0, 0,0,0,0);
        add(0,4,mk(1,1,2,3), 0,4,mk(1,1,2,3), 0,4,mk(1,1,2,3), 5,0,0,0, 0,0,0, 0,0,0,0);
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                5,1,0,1, 0,0,0, 0,0,0,0);
        // Wrap-around at head=6: id1 (age 3) replaced by cache id7 (age 1).
        add(1,1,mk(1,0,32'h300,1), 0,0,NONE, 0,0,NONE, 6,0,0,0, 1,0,0, 1,0,32'h300,1);
        add(0,0,NONE, 0,0,NONE, 1,7,mk(1,32'hDEAD0000,32'h400,4),
            6,0,0,0, 1,0,0, 4,32'hDEAD0000,32'h400,7);
        // id0 (age 2) and equal-age id7 do not replace.
        add(0,0,NONE, 1,0,mk(1,5,32'h500,5), 0,0,NONE, 6,0,0,0, 1,0,0, 4,32'hDEAD0000,32'h400,7);
        add(1,7,mk(1,7,32'h700,2), 0,0,NONE, 0,0,NONE, 6,0,0,0, 1,0,0, 4,32'hDEAD0000,32'h400,7);
        // Promotion needs both head match and done.
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                6,1,0,0, 1,0,0, 4,32'hDEAD0000,32'h400,7);
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                7,0,0,0, 1,0,0, 4,32'hDEAD0000,32'h400,7);
        add(0,0,NONE, 1,0,mk(1,5,32'h500,5), 0,0,NONE, 7,1,0,0, 1,1,0, 4,32'hDEAD0000,32'h400,7);
        // RAISE ignores ext_flush and new candidates.
        add(1,0,mk(1,1,32'h600,6), 0,0,NONE, 0,0,NONE, 7,0,1,0, 1,1,0, 4,32'hDEAD0000,32'h400,7);
        add(0,0,NONE, 1,7,mk(1,8,32'h800,3), 0,0,NONE, 7,0,0,0, 1,1,0, 4,32'hDEAD0000,32'h400,7);
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                7,0,0,1, 0,0,1, 4,32'hDEAD0000,32'h400,7);
        // Candidate during FLUSH is dropped.
        add(0,0,NONE, 1,7,mk(1,8,32'h800,3), 0,0,NONE, 7,0,0,1, 0,0,0, 0,0,0,0);
        add(0,0,NONE, 0,0,NONE, 0,0,NONE,                7,0,0,0, 0,0,0, 0,0,0,0);

        #12;
        chk_all("reset", 0,0,0, 0,0,0,0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clock);
            alu_wb_valid = vecs[i].av; alu_rob_id = vecs[i].aid; alu_rob_xcpt_info = vecs[i].ainfo;
            mul_wb_valid = vecs[i].mv; mul_rob_id = vecs[i].mid; mul_rob_xcpt_info = vecs[i].minfo;
            cache_wb_valid = vecs[i].cv; cache_rob_id = vecs[i].cid; cache_rob_xcpt_info = vecs[i].cinfo;
            rob_head = vecs[i].head; rob_head_done = vecs[i].done;
            ext_flush = vecs[i].fl; xcpt_ack = vecs[i].ack;
            @(posedge clock);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_req, vecs[i].e_flush,
                    vecs[i].e_type, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_id);
        end

        // Asynchronous reset while xcpt_req is high.
        @(negedge clock);
        idle_inputs();
        rob_head = 3'd3;
        alu_wb_valid = 1'b1; alu_rob_id = 3'd3; alu_rob_xcpt_info = mk(1, 32'hA, 32'hB0, 3'd5);
        @(negedge clock);
        idle_inputs();
        rob_head = 3'd3; rob_head_done = 1'b1;
        @(posedge clock);
        #1;
        chk_all("pre_rst", 1,1,0, 5,32'hA,32'hB0,3);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0,0,0, 0,0,0,0);
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        @(posedge clock);
        #1;
        chk_all("post_rst", 0,0,0, 0,0,0,0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_xcpt_scheduler.md
Name: wb_xcpt_scheduler

Overview:
- Collects per-cycle exception reports from the three writeback paths: ALU, MUL and cache.
- Each report is tagged with its ROB index. The block keeps only the oldest pending exception relative to the current ROB head.
- When that instruction reaches the ROB head, the block raises a precise exception request to core control, waits for acknowledge, then pulses a pipeline flush.
- Sits between the writeback exception formatters and the ROB/commit control.

Parameters:
- ROB_IDX_W, 3, ROB index width. ROB holds 2^ROB_IDX_W entries; index arithmetic wraps modulo that size.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- alu_wb_valid  in  1  ALU writeback this cycle
- alu_rob_id  in  ROB_IDX_W  ROB index of the ALU writeback
- alu_rob_xcpt_info  in  68  [67] xcpt valid, [66:35] addr_val, [34:3] pc, [2:0] xcpt type
- mul_wb_valid / mul_rob_id / mul_rob_xcpt_info  in  1 / ROB_IDX_W / 68  same fields for MUL
- cache_wb_valid / cache_rob_id / cache_rob_xcpt_info  in  1 / ROB_IDX_W / 68  same fields for cache
- rob_head  in  ROB_IDX_W  ROB index of the oldest in-flight instruction
- rob_head_done  in  1  head entry has completed writeback
- ext_flush  in  1  external squash (e.g. branch mispredict)
- xcpt_ack  in  1  core control has taken the exception
- xcpt_pending  out  1  an exception is held (states HOLD or RAISE)
- xcpt_req  out  1  exception request to core control
- xcpt_type  out  3  held exception type
- xcpt_addr_val  out  32  held faulting address
- xcpt_pc  out  32  held PC
- xcpt_rob_id  out  ROB_IDX_W  ROB index of the held exception
- rob_flush  out  1  one-cycle flush pulse after acknowledge

Behaviour:
- Reset: state=IDLE; every output and every stored field is 0.
- A candidate is unit u with u_wb_valid=1 and u_rob_xcpt_info[67]=1.
- Age = (rob_id - rob_head) mod 2^ROB_IDX_W, computed with the current-cycle rob_head; smaller age is older.
- Merge (applies in IDLE and HOLD only):
  - Pick the oldest candidate. Equal-age tie priority: ALU > MUL > cache.
  - Capture it if state=IDLE, or if its age is strictly less than the held entry's age.
  - Registered: a capture at cycle t appears on the outputs at t+1, with xcpt_pending=1 and state=HOLD.
- IDLE:
  - ext_flush=1 → candidates that cycle are dropped; stay IDLE.
  - Otherwise, a capture → HOLD.
- HOLD:
  - ext_flush=1 → clear all held fields, → IDLE. ext_flush has priority over merge and promotion.
  - Else if rob_head==xcpt_rob_id and rob_head_done=1 → RAISE. xcpt_req=1 from the next cycle. A merge in this same cycle is suppressed.
  - Else apply merge; stay HOLD.
- RAISE:
  - xcpt_req and all held fields stay stable.
  - New candidates and ext_flush are ignored.
  - xcpt_ack=1 sampled → FLUSH; xcpt_req drops at the next edge.
  - xcpt_ack while not in RAISE is ignored.
- FLUSH:
  - rob_flush=1 for exactly one cycle; xcpt_pending=0.
  - Candidates that cycle are dropped.
  - Next state IDLE; held fields cleared to 0.
- Minimum promotion-to-flush latency: RAISE entered at t+1; ack at t+1 gives rob_flush at t+2.
- Asynchronous reset in any state forces IDLE immediately and clears every output, including an in-flight xcpt_req or rob_flush.
- Wrap-around: rob_id < rob_head is valid and means a young entry. Example with ROB_IDX_W=3 and head=6: id 1 has age 3, id 7 has age 1.

Test Plan:
- Single ALU fault:
  - Stimulus: head=2; ALU valid, id=2, type=3'b011, pc=0x100. Next cycle rob_head_done=1. Ack one cycle after xcpt_req rises.
  - Required: xcpt_pending=1 at t+1; xcpt_req=1 at t+2; rob_flush exactly one pulse the cycle after ack; all outputs return to 0.
- Simultaneous arrivals, oldest wins:
  - Stimulus: head=5; ALU id=7, MUL id=5 (pc=0x200), cache id=6.
  - Required: xcpt_rob_id=5, xcpt_pc=0x200.
- Replacement and wrap-around:
  - Stimulus: head=6; hold id=1 (age 3); then cache dTlb_miss (3'b100), id=7, addr=0xDEAD0000.
  - Required: held entry replaced with type 3'b100, addr_val=0xDEAD0000. A later report with id=0 (age 2) does not replace it.
- Flush races:
  - Stimulus: ext_flush=1 while in HOLD. Separately, ext_flush=1 while in RAISE.
  - Required: HOLD case → IDLE with outputs 0 next cycle. RAISE case → xcpt_req and fields unchanged.
- Non-exception and blocked-state traffic:
  - Stimulus: wb_valid=1 with info[67]=0. Separately, MUL exception arriving during RAISE and during FLUSH.
  - Required: nothing captured in any of these cases.
- Reset mid-RAISE:
  - Stimulus: assert reset while xcpt_req=1.
  - Required: xcpt_req, xcpt_pending and rob_flush go to 0 immediately, without waiting for a clock edge.
